dsi_tx_arbiter: RTL

Shares the single packet-write interface of the DSI lanes controller between two requesters: port 0 (video stream packets) and port 1 (command / LP packets from the register block). It waits for the lanes to be ready, arbitrates by fixed priority with starvation protection, and generates the one-cycle start pulse and the last-word flag. It then pulls words from the granted requester on each lanes-controller data request and inserts a programmable inter-packet gap so the lanes can return to LP-11 between packets.

---
 rtl/dsi_tx_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dsi_tx_arbiter.sv
// Two-port packet arbiter in front of the DSI lanes controller write interface.
// Fixed priority to port 0 with starvation relief for port 1, plus an inter-packet LP gap.
module dsi_tx_arbiter #(
  parameter int unsigned GAP_CYCLES   = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [63:0] req_data,
  input  logic [9:0]  req_strb,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ack,
  output logic [1:0]  grant,
  input  logic        lines_ready,
  input  logic        data_underflow_error,
  output logic [31:0] iface_write_data,
  output logic [4:0]  iface_write_strb,
  output logic        iface_write_rqst,
  output logic        iface_last_word,
  input  logic        iface_data_rqst,
  input  logic        err_clear,
  output logic        err_underflow,
  output logic        err_stall
);

  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);
  localparam logic [7:0] GapLast     = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StStream, StGap} state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  gap_q, gap_d;
  logic        err_stall_q, err_stall_d;
  logic        err_underflow_q, err_underflow_d;
  logic        stall_set;

  // The granted port's current word, muxed by the one-hot grant.
  logic        owner;
  logic [31:0] own_data;
  logic [4:0]  own_strb;
  logic        own_last;
  logic        own_valid;

  assign owner     = grant_q[1];
  assign own_data  = owner ? req_data[63:32] : req_data[31:0];
  assign own_strb  = owner ? req_strb[9:5]   : req_strb[4:0];
  assign own_last  = req_last[owner];
  assign own_valid = req_valid[owner];

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    starve_d         = starve_q;
    gap_d            = gap_q;
    stall_set        = 1'b0;
    req_ack          = 2'b00;
    iface_write_data = '0;
    iface_write_strb = '0;
    iface_write_rqst = 1'b0;
    iface_last_word  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (lines_ready && (req_valid != 2'b00)) begin
          if ((req_valid == 2'b10) || ((req_valid == 2'b11) && (starve_q >= StarveLimit))) begin
            grant_d  = 2'b10;
            starve_d = '0;
          end else begin
            grant_d = 2'b01;
            if ((req_valid == 2'b11) && (starve_q != 4'hF)) begin
              starve_d = starve_q + 4'd1;
            end
          end
          state_d = StStart;
        end
      end
      StStart: begin
        iface_write_rqst = 1'b1;
        iface_write_data = own_data;
        iface_write_strb = own_strb;
        iface_last_word  = own_last;
        req_ack          = grant_q;
        if (own_last) begin
          state_d = StGap;
          grant_d = 2'b00;
          gap_d   = '0;
        end else begin
          state_d = StStream;
        end
      end
      StStream: begin
        iface_write_data = own_data;
        iface_write_strb = own_strb;
        iface_last_word  = own_last;
        if (iface_data_rqst) begin
          if (own_valid) begin
            req_ack = grant_q;
            if (own_last) begin
              state_d = StGap;
              grant_d = 2'b00;
              gap_d   = '0;
            end
          end else begin
            stall_set = 1'b1;
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear wins over a same-cycle set so software never loses a clear.
  always_comb begin
    err_stall_d     = err_clear ? 1'b0 : (err_stall_q | stall_set);
    err_underflow_d = err_clear ? 1'b0 :
                      (err_underflow_q | ((state_q == StStream) && data_underflow_error));
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      grant_q         <= 2'b00;
      starve_q        <= '0;
      gap_q           <= '0;
      err_stall_q     <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      starve_q        <= starve_d;
      gap_q           <= gap_d;
      err_stall_q     <= err_stall_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign grant         = grant_q;
  assign err_stall     = err_stall_q;
  assign err_underflow = err_underflow_q;

endmodule
